craps_game_fsm: RTL and testbench

Downstream consumer of the dice roller. Samples each completed pair of dice values and runs a craps game state machine: come-out roll, point phase, then win or lose. Tracks the established point, rolls in the current game, and saturating win/loss tallies. Feeds the board display and LED logic.

---
 rtl/craps_if.sv | 31 +++
 rtl/craps_game_fsm.sv | 151 +++++++++++++++
 tb/tb_craps_game_fsm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/craps_if.sv
// Roll-in / game-status bus between the dice roller side and the craps game FSM.
interface craps_if #(
    parameter int CNT_W = 8
);
    logic             roll_valid;
    logic [3:0]       dice1;
    logic [3:0]       dice2;
    logic             new_game;
    logic [1:0]       state;
    logic [3:0]       point;
    logic [3:0]       last_sum;
    logic             win;
    logic             lose;
    logic             result_stb;
    logic             bad_roll;
    logic [CNT_W-1:0] roll_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output roll_valid, dice1, dice2, new_game,
        input  state, point, last_sum, win, lose, result_stb, bad_roll,
               roll_cnt, win_cnt, loss_cnt
    );

    modport slave (
        input  roll_valid, dice1, dice2, new_game,
        output state, point, last_sum, win, lose, result_stb, bad_roll,
               roll_cnt, win_cnt, loss_cnt
    );
endinterface

// File: rtl/craps_game_fsm.sv
// Craps game state machine: come-out roll, point phase, terminal win/lose,
// with saturating per-game roll count and win/loss tallies. All outputs registered.
module craps_game_fsm #(
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    craps_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_COME_OUT = 2'b00,
        ST_POINT    = 2'b01,
        ST_WIN      = 2'b10,
        ST_LOSE     = 2'b11
    } state_t;

    state_t           state_r, state_s;
    logic [3:0]       point_r, point_s;
    logic [3:0]       last_sum_r, last_sum_s;
    logic             win_r, win_s;
    logic             lose_r, lose_s;
    logic             result_stb_r, result_stb_s;
    logic             bad_roll_r, bad_roll_s;
    logic [CNT_W-1:0] roll_cnt_r, roll_cnt_s;
    logic [CNT_W-1:0] win_cnt_r, win_cnt_s;
    logic [CNT_W-1:0] loss_cnt_r, loss_cnt_s;

    logic             legal_s;
    logic [3:0]       sum_s;
    logic             in_play_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    function automatic logic die_ok(input logic [3:0] d);
        die_ok = (d >= 4'd1) && (d <= 4'd6);
    endfunction

    // Next-state, next-output and counter update logic
    always_comb begin
        state_s      = state_r;
        point_s      = point_r;
        last_sum_s   = last_sum_r;
        result_stb_s = 1'b0;
        bad_roll_s   = 1'b0;
        roll_cnt_s   = roll_cnt_r;
        win_cnt_s    = win_cnt_r;
        loss_cnt_s   = loss_cnt_r;
        legal_s      = die_ok(bus.dice1) && die_ok(bus.dice2);
        sum_s        = bus.dice1 + bus.dice2;
        in_play_s    = (state_r == ST_COME_OUT) || (state_r == ST_POINT);

        if (bus.new_game) begin
            // new_game wins over a coincident roll; the roll is simply dropped
            state_s    = ST_COME_OUT;
            point_s    = 4'd0;
            roll_cnt_s = {CNT_W{1'b0}};
        end else if (bus.roll_valid && in_play_s) begin
            if (!legal_s) begin
                bad_roll_s = 1'b1;
            end else begin
                last_sum_s = sum_s;
                roll_cnt_s = sat_inc(roll_cnt_r);
                case (state_r)
                    ST_COME_OUT: begin
                        if ((sum_s == 4'd7) || (sum_s == 4'd11)) begin
                            state_s = ST_WIN;
                        end else if ((sum_s == 4'd2) || (sum_s == 4'd3) || (sum_s == 4'd12)) begin
                            state_s = ST_LOSE;
                        end else begin
                            state_s = ST_POINT;
                            point_s = sum_s;
                        end
                    end
                    ST_POINT: begin
                        if (sum_s == point_r) begin
                            state_s = ST_WIN;
                        end else if (sum_s == 4'd7) begin
                            state_s = ST_LOSE;
                        end else begin
                            state_s = ST_POINT;
                        end
                    end
                    default: begin
                        state_s = ST_COME_OUT;
                    end
                endcase
                if (state_s == ST_WIN) begin
                    result_stb_s = 1'b1;
                    win_cnt_s    = sat_inc(win_cnt_r);
                end else if (state_s == ST_LOSE) begin
                    result_stb_s = 1'b1;
                    loss_cnt_s   = sat_inc(loss_cnt_r);
                end else begin
                    result_stb_s = 1'b0;
                end
            end
        end else begin
            case (state_r)
                ST_COME_OUT, ST_POINT, ST_WIN, ST_LOSE: state_s = state_r;
                default:                                state_s = ST_COME_OUT;
            endcase
        end

        win_s  = (state_s == ST_WIN);
        lose_s = (state_s == ST_LOSE);
    end

    // Output and state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_COME_OUT;
            point_r      <= 4'd0;
            last_sum_r   <= 4'd0;
            win_r        <= 1'b0;
            lose_r       <= 1'b0;
            result_stb_r <= 1'b0;
            bad_roll_r   <= 1'b0;
            roll_cnt_r   <= {CNT_W{1'b0}};
            win_cnt_r    <= {CNT_W{1'b0}};
            loss_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            point_r      <= point_s;
            last_sum_r   <= last_sum_s;
            win_r        <= win_s;
            lose_r       <= lose_s;
            result_stb_r <= result_stb_s;
            bad_roll_r   <= bad_roll_s;
            roll_cnt_r   <= roll_cnt_s;
            win_cnt_r    <= win_cnt_s;
            loss_cnt_r   <= loss_cnt_s;
        end
    end

    assign bus.state      = state_r;
    assign bus.point      = point_r;
    assign bus.last_sum   = last_sum_r;
    assign bus.win        = win_r;
    assign bus.lose       = lose_r;
    assign bus.result_stb = result_stb_r;
    assign bus.bad_roll   = bad_roll_r;
    assign bus.roll_cnt   = roll_cnt_r;
    assign bus.win_cnt    = win_cnt_r;
    assign bus.loss_cnt   = loss_cnt_r;
endmodule

// File: tb/tb_craps_game_fsm.sv
// Directed plus randomized bench for craps_game_fsm against a game-rules model.
module tb_craps_game_fsm;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    craps_if #(.CNT_W(CNT_W)) bus ();
    craps_game_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Game model: a point of 0 means still on the come-out roll
    int m_point, m_last, m_rolls, m_wins, m_losses;
    bit m_done, m_won, m_stb, m_bad;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_point = 0; m_last = 0; m_rolls = 0; m_wins = 0; m_losses = 0;
        m_done = 0; m_won = 0; m_stb = 0; m_bad = 0;
    endtask

    task automatic finish_game(input bit w);
        m_done = 1; m_won = w; m_stb = 1;
        if (w) m_wins = (m_wins < CMAX) ? m_wins + 1 : CMAX;
        else   m_losses = (m_losses < CMAX) ? m_losses + 1 : CMAX;
    endtask

    task automatic model_step(input bit ng, input bit rv, input int d1, input int d2);
        int s;
        m_stb = 0; m_bad = 0;
        if (ng) begin
            m_point = 0; m_done = 0; m_rolls = 0;
        end else if (rv && !m_done) begin
            if (d1 < 1 || d1 > 6 || d2 < 1 || d2 > 6) begin
                m_bad = 1;
            end else begin
                s = d1 + d2;
                m_last = s;
                m_rolls = (m_rolls < CMAX) ? m_rolls + 1 : CMAX;
                if (m_point == 0) begin
                    if (s == 7 || s == 11) finish_game(1);
                    else if (s == 2 || s == 3 || s == 12) finish_game(0);
                    else m_point = s;
                end else if (s == m_point) finish_game(1);
                else if (s == 7) finish_game(0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        int es;
        es = m_done ? (m_won ? 2 : 3) : (m_point != 0 ? 1 : 0);
        check({tag, ".state"}, int'(bus.state), es);
        check({tag, ".point"}, int'(bus.point), m_point);
        check({tag, ".last_sum"}, int'(bus.last_sum), m_last);
        check({tag, ".win"}, int'(bus.win), int'(m_done && m_won));
        check({tag, ".lose"}, int'(bus.lose), int'(m_done && !m_won));
        check({tag, ".result_stb"}, int'(bus.result_stb), int'(m_stb));
        check({tag, ".bad_roll"}, int'(bus.bad_roll), int'(m_bad));
        check({tag, ".roll_cnt"}, int'(bus.roll_cnt), m_rolls);
        check({tag, ".win_cnt"}, int'(bus.win_cnt), m_wins);
        check({tag, ".loss_cnt"}, int'(bus.loss_cnt), m_losses);
    endtask

    task automatic step(input string tag, input bit ng, input bit rv,
                        input logic [3:0] d1, input logic [3:0] d2);
        bus.new_game = ng; bus.roll_valid = rv; bus.dice1 = d1; bus.dice2 = d2;
        @(posedge clk);
        model_step(ng, rv, int'(d1), int'(d2));
        #1;
        bus.new_game = 1'b0; bus.roll_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic roll(input string tag, input logic [3:0] d1, input logic [3:0] d2);
        step(tag, 1'b0, 1'b1, d1, d2);
    endtask

    task automatic newg(input string tag);
        step(tag, 1'b1, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        bus.new_game = 1'b0; bus.roll_valid = 1'b0; bus.dice1 = 4'd0; bus.dice2 = 4'd0;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("reset");

        roll("co_7", 4'd3, 4'd4);
        check("co_7.win_cnt_one", int'(bus.win_cnt), 1);
        step("idle_after_win", 1'b0, 1'b0, 4'd0, 4'd0);

        newg("ng1");
        roll("co_2", 4'd1, 4'd1);
        roll("lose_ignore", 4'd2, 4'd2);
        check("lose_ignore.last_sum", int'(bus.last_sum), 2);

        newg("ng2");
        roll("pt6", 4'd4, 4'd2);
        roll("pt_stay4", 4'd3, 4'd1);
        roll("pt_hit6", 4'd5, 4'd1);
        check("pt_hit6.roll_cnt", int'(bus.roll_cnt), 3);

        newg("ng3");
        roll("pt5", 4'd2, 4'd3);
        roll("pt_seven", 4'd3, 4'd4);

        newg("ng4");
        roll("illegal_7_1", 4'd7, 4'd1);
        roll("illegal_0_3", 4'd0, 4'd3);
        check("illegal.state", int'(bus.state), 0);

        for (int g = 0; g < 4; g++) begin
            newg("sat_ng");
            roll("sat_win", 4'd6, 4'd5);
        end
        check("sat.win_cnt", int'(bus.win_cnt), 3);

        newg("ng5");
        step("ng_and_roll", 1'b1, 1'b1, 4'd3, 4'd4);
        check("ng_and_roll.win", int'(bus.win), 0);

        roll("pt8", 4'd4, 4'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        roll("post_rst_11", 4'd5, 4'd6);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] a, b;
            bit ng, rv;
            ng = ($urandom_range(9, 0) == 0);
            rv = ($urandom_range(1, 0) == 1);
            a  = 4'($urandom_range(7, 0));
            b  = 4'($urandom_range(7, 0));
            step("rand", ng, rv, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
